opr_stage: RTL and testbench

//  Registered operand-generation stage between instr decode and execute. Resolves op1/op2 from
//  reg-file read data, forwarded results of NFWD younger-producer stages, or the extended immediate.

---
 rtl/opr_pkg.sv | 28 ++
 rtl/opr_fwd_mux.sv | 54 +++++
 rtl/opr_stage.sv | 110 +++++++++++
 tb/tb_opr_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/opr_pkg.sv
// Shared constants and immediate-extension helper for the operand-generation stage.
package opr_pkg;

  localparam logic [1:0] IMM_ZERO = 2'd0;
  localparam logic [1:0] IMM_SIGN = 2'd1;
  localparam logic [1:0] IMM_HIGH = 2'd2;
  localparam logic [1:0] IMM_RSVD = 2'd3;

  // Container width for the width-generic helper; callers truncate to XLEN.
  localparam int EXT_W = 64;

  function automatic logic [EXT_W-1:0] imm_ext(input logic [EXT_W-1:0] imm,
                                               input logic [1:0]       mode,
                                               input int               immw,
                                               input int               xlen);
    logic [EXT_W-1:0] mask;
    logic [EXT_W-1:0] res;
    mask = (EXT_W'(1) << immw) - EXT_W'(1);
    res  = imm & mask;
    case (mode)
      IMM_SIGN: if (imm[immw-1]) res = res | ~mask;
      IMM_HIGH: res = res << (xlen - immw);
      default:  res = imm & mask;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/opr_fwd_mux.sv
// One operand's source select (forward / reg-file / immediate / zero) and its hazard flag.
module opr_fwd_mux
  import opr_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REGAW = 5,
  parameter int NFWD  = 2
) (
  input  logic                  re,
  input  logic [REGAW-1:0]      rs,
  input  logic [XLEN-1:0]       rdata,
  input  logic                  imm_sel,
  input  logic [XLEN-1:0]       imm_val,
  input  logic [NFWD-1:0]       fwd_valid,
  input  logic [NFWD-1:0]       fwd_pend,
  input  logic [NFWD*REGAW-1:0] fwd_waddr,
  input  logic [NFWD*XLEN-1:0]  fwd_wdata,
  output logic [XLEN-1:0]       operand,
  output logic                  hazard
);

  logic            hit;
  logic            hit_pend;
  logic [XLEN-1:0] hit_data;
  logic            rs_nz;

  assign rs_nz = (rs != '0);

  // Scan oldest to youngest so the youngest matching source overwrites older ones.
  always_comb begin
    hit      = 1'b0;
    hit_pend = 1'b0;
    hit_data = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_waddr[i*REGAW +: REGAW] == rs)) begin
        hit      = 1'b1;
        hit_pend = fwd_pend[i];
        hit_data = fwd_wdata[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    operand = '0;
    if (re) begin
      operand = (hit && rs_nz) ? hit_data : rdata;
    end else if (imm_sel) begin
      operand = imm_val;
    end
  end

  assign hazard = re && rs_nz && hit && hit_pend;

endmodule

// File: rtl/opr_stage.sv
// Registered operand-generation stage: resolves op1/op2, stalls on pending forwards,
// and hands operands to execute over valid/ready with flush support.
module opr_stage
  import opr_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IMMW  = 16,
  parameter int REGAW = 5,
  parameter int NFWD  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  re1,
  input  logic                  re2,
  input  logic [REGAW-1:0]      rs1,
  input  logic [REGAW-1:0]      rs2,
  input  logic [XLEN-1:0]       op1_rdata,
  input  logic [XLEN-1:0]       op2_rdata,
  input  logic [IMMW-1:0]       imm_data,
  input  logic                  imm_valid,
  input  logic [1:0]            imm_mode,
  input  logic [NFWD-1:0]       fwd_valid,
  input  logic [NFWD-1:0]       fwd_pend,
  input  logic [NFWD*REGAW-1:0] fwd_waddr,
  input  logic [NFWD*XLEN-1:0]  fwd_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       op1,
  output logic [XLEN-1:0]       op2
);

  logic [XLEN-1:0] imm_val_p0;
  logic [XLEN-1:0] op1_sel_p0;
  logic [XLEN-1:0] op2_sel_p0;
  logic            haz1_p0;
  logic            haz2_p0;
  logic            capture_p0;

  logic            vld_p1;
  logic [XLEN-1:0] op1_p1;
  logic [XLEN-1:0] op2_p1;

  // Stage p0: combinational operand resolution from decode-time inputs.
  assign imm_val_p0 = XLEN'(imm_ext(EXT_W'(imm_data), imm_mode, IMMW, XLEN));

  opr_fwd_mux #(
    .XLEN  (XLEN),
    .REGAW (REGAW),
    .NFWD  (NFWD)
  ) u_mux1 (
    .re        (re1),
    .rs        (rs1),
    .rdata     (op1_rdata),
    .imm_sel   (imm_valid),
    .imm_val   (imm_val_p0),
    .fwd_valid (fwd_valid),
    .fwd_pend  (fwd_pend),
    .fwd_waddr (fwd_waddr),
    .fwd_wdata (fwd_wdata),
    .operand   (op1_sel_p0),
    .hazard    (haz1_p0)
  );

  opr_fwd_mux #(
    .XLEN  (XLEN),
    .REGAW (REGAW),
    .NFWD  (NFWD)
  ) u_mux2 (
    .re        (re2),
    .rs        (rs2),
    .rdata     (op2_rdata),
    .imm_sel   (imm_valid),
    .imm_val   (imm_val_p0),
    .fwd_valid (fwd_valid),
    .fwd_pend  (fwd_pend),
    .fwd_waddr (fwd_waddr),
    .fwd_wdata (fwd_wdata),
    .operand   (op2_sel_p0),
    .hazard    (haz2_p0)
  );

  // in_ready deliberately ignores flush so decode sees a stable handshake.
  assign in_ready   = !(haz1_p0 || haz2_p0) && (!vld_p1 || out_ready);
  assign capture_p0 = in_valid && in_ready && !flush;

  // Stage p1: output register toward execute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      op1_p1 <= '0;
      op2_p1 <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (capture_p0) begin
      vld_p1 <= 1'b1;
      op1_p1 <= op1_sel_p0;
      op2_p1 <= op2_sel_p0;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign op1       = op1_p1;
  assign op2       = op2_p1;

endmodule

// File: tb/tb_opr_stage.sv
// Self-checking bench for opr_stage: directed scenarios plus a randomized run against a reference model.
module tb_opr_stage;

  localparam int XLEN = 32;
  localparam int IMMW = 16;
  localparam int REGAW = 5;
  localparam int NFWD = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic in_valid;
  logic in_ready;
  logic re1, re2;
  logic [REGAW-1:0] rs1, rs2;
  logic [XLEN-1:0] op1_rdata, op2_rdata;
  logic [IMMW-1:0] imm_data;
  logic imm_valid;
  logic [1:0] imm_mode;
  logic [NFWD-1:0] fwd_valid, fwd_pend;
  logic [REGAW-1:0] fa [NFWD];
  logic [XLEN-1:0] fdat [NFWD];
  logic [NFWD*REGAW-1:0] fwd_waddr;
  logic [NFWD*XLEN-1:0] fwd_wdata;
  logic out_valid;
  logic out_ready;
  logic [XLEN-1:0] op1, op2;

  int total = 0;
  int bad = 0;

  assign fwd_waddr = {fa[1], fa[0]};
  assign fwd_wdata = {fdat[1], fdat[0]};

  always #5 clk = ~clk;

  opr_stage #(.XLEN(XLEN), .IMMW(IMMW), .REGAW(REGAW), .NFWD(NFWD)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .re1(re1), .re2(re2), .rs1(rs1), .rs2(rs2), .op1_rdata(op1_rdata), .op2_rdata(op2_rdata),
    .imm_data(imm_data), .imm_valid(imm_valid), .imm_mode(imm_mode),
    .fwd_valid(fwd_valid), .fwd_pend(fwd_pend), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .op1(op1), .op2(op2)
  );

  // Reference: immediate extension by plain arithmetic.
  function automatic logic [31:0] ref_imm(input logic [15:0] imm, input logic [1:0] mode);
    case (mode)
      2'd1:    return imm[15] ? (32'(imm) + 32'hFFFF0000) : 32'(imm);
      2'd2:    return 32'(imm) * 32'h10000;
      default: return 32'(imm);
    endcase
  endfunction

  // Reference: operand value and hazard from current bench-side inputs.
  task automatic ref_operand(input logic re, input logic [4:0] rs, input logic [31:0] rdata,
                             output logic [31:0] val, output logic haz);
    bit found = 0;
    val = 32'd0;
    haz = 1'b0;
    if (re) begin
      val = rdata;
      for (int i = 0; i < NFWD; i++) begin
        if (!found && rs != 0 && fwd_valid[i] && fa[i] == rs) begin
          found = 1;
          val = fdat[i];
          haz = fwd_pend[i];
        end
      end
    end else if (imm_valid) begin
      val = ref_imm(imm_data, imm_mode);
    end
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; re1 = 0; re2 = 0; rs1 = 0; rs2 = 0;
    op1_rdata = 0; op2_rdata = 0; imm_data = 0; imm_valid = 0; imm_mode = 0;
    fwd_valid = 0; fwd_pend = 0; out_ready = 1;
    for (int i = 0; i < NFWD; i++) begin
      fa[i] = 0;
      fdat[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (op1 !== 32'd0) begin bad++; $display("FAIL reset_op1 got=%h exp=0", op1); end
    total++; if (op2 !== 32'd0) begin bad++; $display("FAIL reset_op2 got=%h exp=0", op2); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tick();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
    end
  endtask

  task automatic test_imm();
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'h00008001;
    exp_tab[1] = 32'hFFFF8001;
    exp_tab[2] = 32'h80010000;
    exp_tab[3] = 32'h00008001;
    clear_inputs();
    for (int m = 0; m < 4; m++) begin
      in_valid = 1; re2 = 0; imm_valid = 1; imm_data = 16'h8001; imm_mode = 2'(m);
      tick();
      total++; if (out_valid !== 1'b1 || op2 !== exp_tab[m])
        begin bad++; $display("FAIL imm_mode%0d got=%h vld=%b exp=%h", m, op2, out_valid, exp_tab[m]); end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    in_valid = 1; re1 = 1; rs1 = 5; op1_rdata = 32'h1234_5678;
    fwd_valid = 2'b11; fa[0] = 5; fa[1] = 5; fdat[0] = 32'hAAAA; fdat[1] = 32'hBBBB;
    tick();
    total++; if (op1 !== 32'hAAAA) begin bad++; $display("FAIL fwd_youngest got=%h exp=0000aaaa", op1); end
    fwd_valid = 2'b10;
    tick();
    total++; if (op1 !== 32'hBBBB) begin bad++; $display("FAIL fwd_older got=%h exp=0000bbbb", op1); end
    rs1 = 0; fwd_valid = 2'b01; fa[0] = 0; fdat[0] = 32'hDEAD;
    tick();
    total++; if (op1 !== 32'h1234_5678) begin bad++; $display("FAIL fwd_r0 got=%h exp=12345678", op1); end
    // Younger non-pending match hides an older pending one.
    rs1 = 9; fa[0] = 9; fa[1] = 9; fwd_valid = 2'b11; fwd_pend = 2'b10; fdat[0] = 32'h77;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fwd_older_pend_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (op1 !== 32'h77) begin bad++; $display("FAIL fwd_older_pend_op got=%h exp=77", op1); end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    tick();
    in_valid = 1; re2 = 1; rs2 = 7; op2_rdata = 32'h0BAD_0BAD;
    fwd_valid = 2'b01; fwd_pend = 2'b01; fa[0] = 7; fdat[0] = 32'hCAFE_F00D;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL loaduse_ready c%0d got=%b exp=0", c, in_ready); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL loaduse_vld c%0d got=%b exp=0", c, out_valid); end
    end
    fwd_pend = 2'b00;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL loaduse_release got=%b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || op2 !== 32'hCAFE_F00D)
      begin bad++; $display("FAIL loaduse_op2 got=%h vld=%b exp=cafef00d", op2, out_valid); end
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    clear_inputs();
    in_valid = 1; re1 = 1; re2 = 1; rs1 = 3; rs2 = 4;
    op1_rdata = 32'h1111_0001; op2_rdata = 32'h2222_0002;
    tick();
    out_ready = 0;
    for (int c = 0; c < 4; c++) begin
      op1_rdata = $urandom; op2_rdata = $urandom;
      fwd_valid = 2'b01; fa[0] = 3; fdat[0] = $urandom;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready c%0d got=%b exp=0", c, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || op1 !== 32'h1111_0001 || op2 !== 32'h2222_0002)
        begin bad++; $display("FAIL bp_hold c%0d got=%h/%h vld=%b exp=11110001/22220002", c, op1, op2, out_valid); end
    end
    fwd_valid = 0; op1_rdata = 32'h3333_0003; op2_rdata = 32'h4444_0004; out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || op1 !== 32'h3333_0003 || op2 !== 32'h4444_0004)
      begin bad++; $display("FAIL bp_next got=%h/%h vld=%b exp=33330003/44440004", op1, op2, out_valid); end
    clear_inputs();
    tick();
  endtask

  task automatic test_flush();
    clear_inputs();
    in_valid = 1; re1 = 1; rs1 = 2; op1_rdata = 32'h5555;
    tick();
    op1_rdata = 32'h6666; flush = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_vld got=%b exp=0", out_valid); end
    flush = 0; in_valid = 0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
    // Async reset in the middle of a stall.
    in_valid = 1; op1_rdata = 32'h7777;
    tick();
    out_ready = 0;
    tick();
    #2 rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_rst_vld got=%b exp=0", out_valid); end
    out_ready = 1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_no_capture got=%b exp=0", out_valid); end
    #2 rst_n = 1;
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic vld_m;
    logic [31:0] op1_m, op2_m, v1, v2;
    logic h1, h2, rdy_m, cap_m;
    clear_inputs();
    tick();
    tick();
    vld_m = 0; op1_m = 0; op2_m = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      re1 = $urandom_range(0, 1); re2 = $urandom_range(0, 1);
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      op1_rdata = $urandom; op2_rdata = $urandom;
      imm_data = 16'($urandom); imm_mode = 2'($urandom_range(0, 3));
      imm_valid = (!re1 || !re2) ? 1'b1 : 1'($urandom_range(0, 1));
      fwd_valid = 2'($urandom_range(0, 3));
      fwd_pend = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      for (int i = 0; i < NFWD; i++) begin
        fa[i] = 5'($urandom_range(0, 3));
        fdat[i] = $urandom;
      end
      #1;
      ref_operand(re1, rs1, op1_rdata, v1, h1);
      ref_operand(re2, rs2, op2_rdata, v2, h2);
      rdy_m = !(h1 || h2) && (!vld_m || out_ready);
      cap_m = in_valid && rdy_m && !flush;
      total++; if (in_ready !== rdy_m) begin bad++; $display("FAIL rnd_ready n%0d got=%b exp=%b", n, in_ready, rdy_m); end
      if (flush) vld_m = 0;
      else if (cap_m) begin vld_m = 1; op1_m = v1; op2_m = v2; end
      else if (out_ready) vld_m = 0;
      tick();
      total++; if (out_valid !== vld_m) begin bad++; $display("FAIL rnd_vld n%0d got=%b exp=%b", n, out_valid, vld_m); end
      if (vld_m) begin
        total++; if (op1 !== op1_m || op2 !== op2_m)
          begin bad++; $display("FAIL rnd_ops n%0d got=%h/%h exp=%h/%h", n, op1, op2, op1_m, op2_m); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_imm();
    test_forwarding();
    test_load_use();
    test_backpressure();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
